// File: rtl/e203_subsys_pllseq_pkg.sv
// Shared types and reset defaults for the PLL reconfiguration sequencer.
// E203_PLLSEQ_CFG_CHECK_EN enables the illegal-setting check helper's use in the top.
package e203_subsys_pllseq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE_BYP = 3'd0,
    ST_RUN      = 3'd1,
    ST_SWBYP    = 3'd2,
    ST_PWRDN    = 3'd3,
    ST_PROG     = 3'd4,
    ST_LOCK     = 3'd5,
    ST_SWPLL    = 3'd6
  } state_e;

  localparam logic [1:0] OD_RST     = 2'd2;
  localparam logic [7:0] M_RST      = 8'd32;
  localparam logic [4:0] N_RST      = 5'd1;
  localparam logic       DIVBY1_RST = 1'b1;
  localparam logic [5:0] DIV_RST    = 6'd0;

  typedef struct packed {
    logic       bypass;
    logic [1:0] od;
    logic [7:0] m;
    logic [4:0] n;
    logic       divby1;
    logic [5:0] div;
  } cfg_t;

  // Settings the PLL cannot lock with; a bypass request never programs them.
  function automatic logic cfg_invalid(cfg_t c);
    return !c.bypass && ((c.n == 5'd0) || (c.m < 8'd2) || (c.od == 2'd3));
  endfunction

endpackage

// File: rtl/e203_subsys_pllseq_tmr.sv
// Shared down-counter for the sequencer: load N-1 on state entry, flag zero.
module e203_subsys_pllseq_tmr #(
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/e203_subsys_pllseq.sv
// PLL reconfiguration sequencer: bypass, power down, reprogram, reset, lock, switch back.
// Build option E203_PLLSEQ_CFG_CHECK_EN rejects illegal OD/M/N requests with cfg_err.
//
// state    | meaning
// IDLE_BYP | PLL asleep in reset, crystal clock selected
// RUN      | PLL locked and selected
// SWBYP    | mux moved to crystal, waiting for glitch-free switch
// PWRDN    | one cycle with PLL asleep and in reset
// PROG     | new settings applied, PLL awake, reset held
// LOCK     | reset released, waiting for lock
// SWPLL    | mux moved back to PLL, waiting for switch
module e203_subsys_pllseq
  import e203_subsys_pllseq_pkg::*;
#(
  parameter int BYP_SETTLE  = 8,
  parameter int RST_CYCLES  = 16,
  parameter int LOCK_CYCLES = 1024,
  parameter int CNT_W       = 11
) (
  input  logic       hfextclk,
  input  logic       hfclkrst,
  input  logic       cfg_req,
  output logic       cfg_ack,
  output logic       cfg_err,
  input  logic       cfg_bypass,
  input  logic [1:0] cfg_od,
  input  logic [7:0] cfg_m,
  input  logic [4:0] cfg_n,
  input  logic       cfg_divby1,
  input  logic [5:0] cfg_div,
  output logic       busy,
  output logic       pllbypass,
  output logic       pll_ASLEEP,
  output logic       pll_RESET,
  output logic [1:0] pll_OD,
  output logic [7:0] pll_M,
  output logic [4:0] pll_N,
  output logic       plloutdivby1,
  output logic [5:0] plloutdiv
);

  localparam logic [CNT_W-1:0] BYP_LD  = CNT_W'(BYP_SETTLE - 1);
  localparam logic [CNT_W-1:0] RST_LD  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LD = CNT_W'(LOCK_CYCLES - 1);

  state_e           state;
  cfg_t             shadow;
  cfg_t             cfg_in;
  logic             req_bad;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_zero;

  always_comb begin
    cfg_in.bypass = cfg_bypass;
    cfg_in.od     = cfg_od;
    cfg_in.m      = cfg_m;
    cfg_in.n      = cfg_n;
    cfg_in.divby1 = cfg_divby1;
    cfg_in.div    = cfg_div;
`ifdef E203_PLLSEQ_CFG_CHECK_EN
    req_bad = cfg_invalid(cfg_in);
`else
    req_bad = 1'b0;
`endif
  end

  // Timer loads coincide with the edge that enters a timed state.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      ST_IDLE_BYP: if (cfg_req && !req_bad && !cfg_bypass) begin tmr_load = 1'b1; tmr_val = RST_LD;  end
      ST_RUN:      if (cfg_req && !req_bad)                begin tmr_load = 1'b1; tmr_val = BYP_LD;  end
      ST_PWRDN:    if (!shadow.bypass)                     begin tmr_load = 1'b1; tmr_val = RST_LD;  end
      ST_PROG:     if (tmr_zero)                           begin tmr_load = 1'b1; tmr_val = LOCK_LD; end
      ST_LOCK:     if (tmr_zero)                           begin tmr_load = 1'b1; tmr_val = BYP_LD;  end
      default: ;
    endcase
  end

  e203_subsys_pllseq_tmr #(.CNT_W(CNT_W)) u_tmr (
    .clk      (hfextclk),
    .rst      (hfclkrst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge hfextclk or posedge hfclkrst) begin
    if (hfclkrst) begin
      state        <= ST_IDLE_BYP;
      shadow       <= '{bypass: 1'b1, od: OD_RST, m: M_RST, n: N_RST, divby1: DIVBY1_RST, div: DIV_RST};
      pllbypass    <= 1'b1;
      pll_ASLEEP   <= 1'b1;
      pll_RESET    <= 1'b1;
      pll_OD       <= OD_RST;
      pll_M        <= M_RST;
      pll_N        <= N_RST;
      plloutdivby1 <= DIVBY1_RST;
      plloutdiv    <= DIV_RST;
      cfg_ack      <= 1'b0;
      cfg_err      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      cfg_ack <= 1'b0;
      cfg_err <= 1'b0;
      case (state)
        ST_IDLE_BYP: begin
          if (cfg_req) begin
            if (req_bad) begin
              cfg_err <= 1'b1;
            end else begin
              shadow <= cfg_in;
              if (cfg_bypass) begin
                cfg_ack <= 1'b1;
              end else begin
                state        <= ST_PROG;
                pll_OD       <= cfg_od;
                pll_M        <= cfg_m;
                pll_N        <= cfg_n;
                plloutdivby1 <= cfg_divby1;
                plloutdiv    <= cfg_div;
                pll_ASLEEP   <= 1'b0;
                pll_RESET    <= 1'b1;
                busy         <= 1'b1;
              end
            end
          end
        end
        ST_RUN: begin
          if (cfg_req) begin
            if (req_bad) begin
              cfg_err <= 1'b1;
            end else begin
              shadow    <= cfg_in;
              state     <= ST_SWBYP;
              pllbypass <= 1'b1;
              busy      <= 1'b1;
            end
          end
        end
        ST_SWBYP: begin
          if (tmr_zero) begin
            state      <= ST_PWRDN;
            pll_ASLEEP <= 1'b1;
            pll_RESET  <= 1'b1;
          end
        end
        ST_PWRDN: begin
          if (shadow.bypass) begin
            state   <= ST_IDLE_BYP;
            cfg_ack <= 1'b1;
            busy    <= 1'b0;
          end else begin
            state        <= ST_PROG;
            pll_OD       <= shadow.od;
            pll_M        <= shadow.m;
            pll_N        <= shadow.n;
            plloutdivby1 <= shadow.divby1;
            plloutdiv    <= shadow.div;
            pll_ASLEEP   <= 1'b0;
          end
        end
        ST_PROG: begin
          if (tmr_zero) begin
            state     <= ST_LOCK;
            pll_RESET <= 1'b0;
          end
        end
        ST_LOCK: begin
          if (tmr_zero) begin
            state     <= ST_SWPLL;
            pllbypass <= 1'b0;
          end
        end
        ST_SWPLL: begin
          if (tmr_zero) begin
            state   <= ST_RUN;
            cfg_ack <= 1'b1;
            busy    <= 1'b0;
          end
        end
        default: state <= ST_IDLE_BYP;
      endcase
    end
  end

endmodule
